// File: rtl/echo_delay_queue.sv
// Echo queue: payload+OFFSET re-emitted DELAY cycles after acceptance, in order; up to DEPTH outstanding.
// Latency DELAY cycles when idle; request RDY drops when DEPTH requests are outstanding, with no same-cycle pop bypass.

module echo_delay_queue_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_vld_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_vld_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
endmodule

module echo_delay_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OFFSET = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         request_say__ENA,
  input  logic [WIDTH-1:0]             request_say_v,
  output logic                         request_say__RDY,
  output logic                         indication_heard__ENA,
  output logic [WIDTH-1:0]             indication_heard_v,
  input  logic                         indication_heard__RDY,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int unsigned OW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

  logic [OW-1:0]    occ_q, occ_d;
  logic             req_xfer, ind_xfer;
  logic [WIDTH-1:0] req_sum;
  logic             q_push;
  logic [WIDTH-1:0] q_push_dat;
  logic [WIDTH-1:0] q_head;
  logic             q_empty;

  assign request_say__RDY      = ~RST & (occ_q < OW'(DEPTH));
  assign indication_heard__ENA = ~RST & ~q_empty;
  assign indication_heard_v    = indication_heard__ENA ? q_head : '0;
  assign occupancy             = RST ? '0 : occ_q;

  assign req_xfer = request_say__ENA & request_say__RDY;
  assign ind_xfer = indication_heard__RDY & indication_heard__ENA;
  assign req_sum  = request_say_v + OFF;

  // The last delay stage feeds the queue so an entry is visible exactly DELAY cycles after capture.
  if (DELAY == 1) begin : g_direct
    assign q_push     = req_xfer;
    assign q_push_dat = req_sum;
  end else begin : g_line
    logic [DELAY-2:0] vld_q;
    logic [WIDTH-1:0] dat_q [DELAY-1];

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= req_xfer;
        for (int i = 1; i < int'(DELAY) - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge CLK) begin
      dat_q[0] <= req_sum;
      for (int i = 1; i < int'(DELAY) - 1; i++) dat_q[i] <= dat_q[i-1];
    end

    assign q_push     = vld_q[DELAY-2];
    assign q_push_dat = dat_q[DELAY-2];
  end

  echo_delay_queue_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_q (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_vld_i (q_push),
    .push_dat_i (q_push_dat),
    .pop_i      (ind_xfer),
    .head_dat_o (q_head),
    .empty_o    (q_empty)
  );

  always_comb begin
    occ_d = occ_q;
    case ({req_xfer, ind_xfer})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) occ_q <= '0;
    else     occ_q <= occ_d;
  end
endmodule

// File: tb/tb_echo_delay_queue.sv
// Bench for echo_delay_queue: directed scenarios plus a random stream, all checked every cycle
// against a list of accepted-but-undelivered requests tagged with their acceptance cycle.
module tb_echo_delay_queue;
  localparam int WIDTH  = 8;
  localparam int DELAY  = 2;
  localparam int DEPTH  = 4;
  localparam int OFFSET = 3;
  localparam int OW     = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] OFF8 = 8'(OFFSET);

  logic             CLK = 1'b0;
  logic             rst = 1'b1;
  logic             say_ena = 1'b0;
  logic [WIDTH-1:0] say_v = '0;
  logic             say_rdy;
  logic             heard_ena;
  logic [WIDTH-1:0] heard_v;
  logic             heard_rdy = 1'b0;
  logic [OW-1:0]    occ;

  typedef struct {
    logic [WIDTH-1:0] v;
    int               t;
  } ent_t;

  ent_t pend[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   last_rx;

  echo_delay_queue #(
    .WIDTH(WIDTH), .DELAY(DELAY), .DEPTH(DEPTH), .OFFSET(OFFSET)
  ) dut (
    .CLK                   (CLK),
    .RST                   (rst),
    .request_say__ENA      (say_ena),
    .request_say_v         (say_v),
    .request_say__RDY      (say_rdy),
    .indication_heard__ENA (heard_ena),
    .indication_heard_v    (heard_v),
    .indication_heard__RDY (heard_rdy),
    .occupancy             (occ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then apply the cycle's transfers to the model.
  task automatic step();
    logic             exp_rdy, exp_ena;
    logic [WIDTH-1:0] exp_v;
    logic [OW-1:0]    exp_occ;
    bit               rx, ix;
    @(negedge CLK);
    if (rst) begin
      exp_rdy = 1'b0; exp_ena = 1'b0; exp_v = '0; exp_occ = '0;
    end else begin
      exp_occ = OW'(pend.size());
      exp_rdy = pend.size() < DEPTH;
      exp_ena = (pend.size() > 0) && (pend[0].t + DELAY <= cyc);
      exp_v   = exp_ena ? pend[0].v + OFF8 : '0;
    end
    chk("say_rdy", 32'(say_rdy), 32'(exp_rdy));
    chk("heard_ena", 32'(heard_ena), 32'(exp_ena));
    chk("occupancy", 32'(occ), 32'(exp_occ));
    if (exp_ena || rst) chk("heard_v", 32'(heard_v), 32'(exp_v));
    rx = say_ena && exp_rdy;
    ix = heard_rdy && exp_ena;
    @(posedge CLK);
    if (rst) begin
      pend.delete();
    end else begin
      if (ix) void'(pend.pop_front());
      if (rx) pend.push_back('{v: say_v, t: cyc});
    end
    last_rx = rx;
    cyc++;
    #1;
  endtask

  initial begin
    int sent;
    logic [WIDTH-1:0] nxt;

    // Reset, then the isolated single request.
    repeat (3) step();
    rst = 1'b0;
    heard_rdy = 1'b1;
    repeat (3) step();
    say_ena = 1'b1; say_v = 8'h05;
    step();
    say_ena = 1'b0;
    repeat (4) step();

    // Fill to DEPTH with consumer stalled; extra requests must be ignored while full.
    heard_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      say_ena = 1'b1; say_v = 8'(i);
      step();
    end
    say_v = 8'h55;
    repeat (4) step();
    heard_rdy = 1'b1;
    repeat (2) step();
    say_ena = 1'b0;
    repeat (8) step();

    // Offset carry wrap.
    say_ena = 1'b1; say_v = 8'hFE; step();
    say_v = 8'h10; step();
    say_ena = 1'b0;
    repeat (4) step();

    // Random-backpressure stream of incrementing values.
    sent = 0;
    nxt = 8'h00;
    for (int n = 0; n < 2000 && sent < 100; n++) begin
      say_ena   = ($urandom_range(0, 3) != 0);
      say_v     = nxt;
      heard_rdy = $urandom_range(0, 1) == 1;
      step();
      if (last_rx) begin
        nxt++;
        sent++;
      end
    end
    chk("stream_sent", 32'(sent), 32'd100);
    say_ena = 1'b0;
    heard_rdy = 1'b1;
    repeat (10) step();

    // Reset with three requests in flight; nothing stale may emerge afterwards.
    heard_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      say_ena = 1'b1; say_v = 8'(8'hA0 + i);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    say_ena = 1'b0;
    heard_rdy = 1'b1;
    repeat (2 * DELAY + 2) step();

    // Random payloads with occasional resets.
    for (int n = 0; n < 300; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      say_ena   = $urandom_range(0, 1) == 1;
      say_v     = 8'($urandom);
      heard_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;
    say_ena = 1'b0;
    heard_rdy = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/echo_delay_queue.md
ECHO_DELAY_QUEUE -- requirements
Module: echo_delay_queue

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..64).
REQ-002 Parameter DELAY, default 2, minimum cycles from request acceptance to indication eligibility (1..16).
REQ-003 Parameter DEPTH, default 4, maximum requests outstanding, delay line plus output queue (power of two, 2..64).
REQ-004 Parameter OFFSET, default 0, constant added to every payload before indication.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 request$say__ENA  input  1  request valid.
REQ-008 request$say$v  input  WIDTH  request payload.
REQ-009 request$say__RDY  output  1  block can accept a request this cycle.
REQ-010 indication$heard__ENA  output  1  indication valid.
REQ-011 indication$heard$v  output  WIDTH  indication payload.
REQ-012 indication$heard__RDY  input  1  consumer accepts indication this cycle.
REQ-013 occupancy  output  clog2(DEPTH+1)  requests accepted but not yet delivered.

Function
REQ-014 Request transfer SHALL occur in a cycle where request$say__ENA and request$say__RDY are both 1; no other cycle captures payload.
REQ-015 Indication transfer SHALL occur in a cycle where indication$heard__ENA and indication$heard__RDY are both 1.
REQ-016 request$say__RDY SHALL equal (occupancy < DEPTH) and RST low; it SHALL NOT depend combinationally on indication$heard__RDY (no same-cycle pop bypass).
REQ-017 A request transferred in cycle t SHALL make its indication visible no earlier than cycle t+DELAY; with an empty queue and continuous indication$heard__RDY=1, exactly in cycle t+DELAY.
REQ-018 indication$heard$v SHALL equal (accepted payload + OFFSET) mod 2^WIDTH; carry discarded.
REQ-019 Indications SHALL be delivered in acceptance order; no loss, duplication or reordering.
REQ-020 Delay line SHALL be fully pipelined: one new request per cycle sustained while RDY, each aging independently.
REQ-021 Matured entries SHALL wait in an output queue while indication$heard__RDY is low; delay-line entries keep aging and enter the queue in order.
REQ-022 indication$heard__ENA SHALL be 1 exactly when the output queue is non-empty; indication$heard$v SHALL be queue head and stable while ENA=1 and RDY=0.
REQ-023 occupancy SHALL increment on request transfer, decrement on indication transfer, and be unchanged when both or neither occur in a cycle.
REQ-024 occupancy SHALL never exceed DEPTH; queue storage SHALL be sized so no overflow is reachable; pointers wrap modulo DEPTH.
REQ-025 request$say__ENA while request$say__RDY=0 SHALL be ignored with no state change.
REQ-026 indication$heard__RDY while indication$heard__ENA=0 SHALL be ignored.
REQ-027 All outputs SHALL be driven from registers or from registered state through logic not involving request$say__ENA, request$say$v or indication$heard__RDY.

Reset
REQ-028 RST high at a rising edge SHALL clear delay line, queue pointers, valid bits and occupancy to 0, discarding in-flight entries.
REQ-029 While RST is high: request$say__RDY=0, indication$heard__ENA=0, occupancy=0; indication$heard$v SHALL be 0.
REQ-030 First cycle after RST falls: request$say__RDY=1, indication$heard__ENA=0.
REQ-031 Reset mid-operation SHALL drop all pending entries; no indication from pre-reset requests ever appears.

Verification
REQ-032 DELAY=2, OFFSET=0: single request v=0x00000005 at cycle 10, heard__RDY=1 -> ENA=1, v=0x00000005 at cycle 12 only; occupancy 1 in cycles 11-12, 0 at 13.
REQ-033 DEPTH=4: requests 1,2,3,4 at cycles 0-3, heard__RDY=0 -> say__RDY=0 from cycle 4, occupancy=4; ENA held with v=1; set heard__RDY=1 at cycle 8 -> outputs 1,2,3,4 in cycles 8-11, say__RDY=1 from cycle 9.
REQ-034 Full plus simultaneous events: occupancy=4, heard__RDY=1 and say__ENA=1 in same cycle -> pop occurs, no push (RDY was 0); occupancy 3 next cycle.
REQ-035 WIDTH=8, OFFSET=3: request v=0xFE -> indication v=0x01; v=0x10 -> 0x13.
REQ-036 Back-to-back stream of 100 incrementing values, heard__RDY random 50% -> in-order delivery, each no earlier than acceptance+DELAY, occupancy never exceeds DEPTH.
REQ-037 Three requests in flight, RST high one cycle -> ENA=0, occupancy=0, say__RDY=0 during reset, say__RDY=1 after; no stale indication within 2*DELAY cycles.
